inst_prefetch_queue: RTL and testbench

//  Instruction prefetch queue between the pipeline IF stage and a variable-latency instruction memory.

---
 rtl/inst_prefetch_queue_if.sv | 27 ++
 rtl/inst_prefetch_queue.sv | 94 +++++++++
 tb/tb_inst_prefetch_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: redirect, IF-side handshake and instruction-memory bus of the prefetch queue
//   redirect_i/redirect_pc_i       flush and restart fetch at a new PC
//   valid_o/inst_o/pc_o/ready_i    head-of-queue handshake towards IF
//   mem_req_o/mem_addr_o/mem_gnt_i request channel towards instruction memory
//   mem_rvalid_i/mem_rdata_i       in-order response channel from instruction memory
//   master: prefetch queue side, slave: core + memory side
interface inst_prefetch_queue_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    modport master (
        input  redirect_i, redirect_pc_i, ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher with in-order FIFO, credit-limited issue and redirect flush
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  inst_prefetch_queue_if.master: redirect, IF head handshake, memory request/response
module inst_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input logic                   clk,
    input logic                   rst,
    inst_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW = $clog2(MAX_OUTSTANDING + 2);
    typedef enum logic {BOOT, RUN} state_t;
    state_t        r_state;
    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pc [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_out;
    logic [DW-1:0] r_drop;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_addr;
    logic          r_req;
    logic          w_gnt;
    logic          w_held;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic          w_raise;
    logic [CW-1:0] w_count_n;
    logic [OW-1:0] w_out_n;
    logic [DW-1:0] w_drop_n;
    logic [31:0]   w_fpc;
    always_comb begin
        w_gnt     = r_req & bus.mem_gnt_i;
        w_held    = r_req & ~bus.mem_gnt_i;
        w_rsp     = bus.mem_rvalid_i;
        w_push    = w_rsp & (r_drop == '0) & ~bus.redirect_i;
        w_pop     = bus.valid_o & bus.ready_i & ~bus.redirect_i;
        w_count_n = bus.redirect_i ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        w_out_n   = r_out + OW'(w_gnt) - OW'(w_rsp);
        // Everything still in flight after this cycle, plus a held request, becomes stale on redirect
        w_drop_n  = bus.redirect_i ? DW'(w_out_n) + DW'(w_held)
                                   : r_drop - DW'(w_rsp && r_drop != '0);
        w_fpc     = bus.redirect_i ? (bus.redirect_pc_i & ~32'h3) : r_fetch_pc;
        // Issue decision uses next-cycle occupancy so the registered request respects the credit limit
        w_raise   = r_state == RUN && !w_held
                    && (32'(w_count_n) + 32'(w_out_n)) < DEPTH
                    && 32'(w_out_n) < MAX_OUTSTANDING;
    end
    assign bus.valid_o    = r_count != '0;
    assign bus.inst_o     = bus.valid_o ? r_inst[r_rptr] : '0;
    assign bus.pc_o       = bus.valid_o ? r_pc[r_rptr] : '0;
    assign bus.mem_req_o  = r_req;
    assign bus.mem_addr_o = r_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
        end else begin
            r_state    <= RUN;
            r_count    <= w_count_n;
            r_out      <= w_out_n;
            r_drop     <= w_drop_n;
            r_wptr     <= bus.redirect_i ? '0 : r_wptr + AW'(w_push);
            r_rptr     <= bus.redirect_i ? '0 : r_rptr + AW'(w_pop);
            // Non-dropped responses arrive in order starting at the last restart PC, so their PC is a running counter
            r_rsp_pc   <= bus.redirect_i ? w_fpc : r_rsp_pc + (w_push ? 32'd4 : 32'd0);
            r_req      <= w_held | w_raise;
            r_fetch_pc <= w_raise ? w_fpc + 32'd4 : w_fpc;
            if (w_raise)
                r_addr <= w_fpc;
            if (w_push) begin
                r_inst[r_wptr] <= bus.mem_rdata_i;
                r_pc[r_wptr]   <= r_rsp_pc;
            end
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed, table-driven and randomized checks of the prefetch queue against a transaction-level model
module tb_inst_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    typedef struct {logic [31:0] addr; bit stale; int due;} fl_t;
    typedef struct {logic [31:0] target; logic [31:0] e0; logic [31:0] e1; logic [31:0] e2;} vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    inst_prefetch_queue_if bus();
    inst_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          gnt_pct = 100;
    int          rdy_pct = 100;
    int          redir_pct = 0;
    bit          do_redir = 0;
    logic [31:0] redir_pc = '0;
    fl_t         infl[$];
    logic [31:0] mq[$];
    logic [31:0] pops[$];
    logic [31:0] gnts[$];
    bit          pend_stale, prev_req, prev_gnt;
    logic [31:0] nf, prev_addr;

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare DUT outputs with the model, choose inputs, then advance the model by this cycle's events
    task automatic step();
        fl_t f;
        bit  rsp, gnt, rdy, redir;
        @(negedge clk);
        cyc++;
        chk("valid_o", 32'(bus.valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("pc_o", bus.pc_o, mq[0]);
            chk("inst_o", bus.inst_o, memword(mq[0]));
        end
        if (prev_req && !prev_gnt) begin
            chk("req_hold", 32'(bus.mem_req_o), 32'd1);
            chk("addr_hold", bus.mem_addr_o, prev_addr);
        end else if (bus.mem_req_o)
            chk("credit", 32'(mq.size() + infl.size() < DEPTH && infl.size() < MAX_OUT), 32'd1);
        rsp   = infl.size() != 0 && infl[0].due <= cyc;
        gnt   = bus.mem_req_o && $urandom_range(99) < gnt_pct;
        rdy   = $urandom_range(99) < rdy_pct;
        redir = do_redir || $urandom_range(999) < redir_pct;
        if (!do_redir && redir)
            redir_pc = $urandom_range(1) != 0 ? $urandom() : 32'hFFFF_FFF0 + $urandom_range(15);
        do_redir = 0;
        bus.mem_gnt_i     = gnt;
        bus.mem_rvalid_i  = rsp;
        bus.mem_rdata_i   = rsp ? memword(infl[0].addr) : '0;
        bus.ready_i       = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = redir_pc;
        if (mq.size() != 0 && rdy && !redir) begin
            pops.push_back(bus.pc_o);
            mq.delete(0);
        end
        if (rsp) begin
            f = infl.pop_front();
            if (!f.stale && !redir)
                mq.push_back(f.addr);
        end
        if (gnt) begin
            gnts.push_back(bus.mem_addr_o);
            if (!pend_stale) begin
                chk("fetch_addr", bus.mem_addr_o, nf);
                nf += 4;
            end
            infl.push_back('{bus.mem_addr_o, pend_stale, cyc + (lat > 0 ? lat : int'($urandom_range(1, 4)))});
            pend_stale = 0;
        end
        if (redir) begin
            foreach (infl[i]) infl[i].stale = 1;
            pend_stale = bus.mem_req_o && !gnt;
            mq.delete();
            nf = redir_pc & ~32'h3;
        end
        if (mq.size() > DEPTH)
            chk("queue_overflow", mq.size(), DEPTH);
        prev_req  = bus.mem_req_o;
        prev_gnt  = gnt;
        prev_addr = bus.mem_addr_o;
    endtask

    // Core and memory are reset together, so the model starts empty
    task automatic do_reset();
        rst = 1;
        bus.redirect_i = 0;
        bus.redirect_pc_i = '0;
        bus.ready_i = 0;
        bus.mem_gnt_i = 0;
        bus.mem_rvalid_i = 0;
        bus.mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, RESET_PC);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_pc", bus.pc_o, 32'd0);
        infl.delete();
        mq.delete();
        pops.delete();
        gnts.delete();
        pend_stale = 0;
        prev_req = 0;
        prev_gnt = 0;
        prev_addr = RESET_PC;
        nf = RESET_PC;
        rst = 0;
    endtask

    task automatic wait_pops(int n, string name);
        for (int k = 0; k < 60 && pops.size() < n; k++) step();
        chk(name, 32'(pops.size() >= n), 32'd1);
    endtask

    task automatic wait_gnts(int n, string name);
        for (int k = 0; k < 30 && gnts.size() < n; k++) step();
        chk(name, 32'(gnts.size() >= n), 32'd1);
    endtask

    initial begin
        vec_t        vt [4];
        int          n;
        logic [31:0] hold_addr;
        vt[0] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vt[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vt[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vt[3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
        // Startup latency and one instruction per cycle from RESET_PC
        do_reset();
        n = 0;
        while (!bus.valid_o && n < 20) begin
            step();
            n++;
        end
        chk("first_valid_by_cycle4", 32'(n <= 4), 32'd1);
        repeat (7) step();
        chk("throughput", pops.size(), 8);
        if (pops.size() >= 8)
            for (int i = 0; i < 8; i++) chk("seq_pc", pops[i], 32'(4 * i));
        // IF stall fills the queue and stops fetch; release drains in order and resumes at 16
        do_reset();
        rdy_pct = 0;
        repeat (14) step();
        chk("req_stops_when_full", 32'(bus.mem_req_o), 32'd0);
        pops.delete();
        gnts.delete();
        rdy_pct = 100;
        wait_pops(4, "drain_timeout");
        if (pops.size() >= 4)
            for (int i = 0; i < 4; i++) chk("drain_pc", pops[i], 32'(4 * i));
        wait_gnts(1, "resume_timeout");
        if (gnts.size() >= 1) chk("resume_addr", gnts[0], 32'd16);
        // Slow memory with requests in flight, then redirect
        do_reset();
        lat = 3;
        repeat (12) step();
        pops.delete();
        do_redir = 1;
        redir_pc = 32'h100;
        wait_pops(1, "redirect_slow_timeout");
        if (pops.size() >= 1) chk("redirect_slow_pc", pops[0], 32'h100);
        // Redirect while a request is held ungranted
        do_reset();
        lat = 1;
        gnt_pct = 0;
        repeat (3) step();
        chk("req_raised", 32'(bus.mem_req_o), 32'd1);
        hold_addr = bus.mem_addr_o;
        do_redir = 1;
        redir_pc = 32'h200;
        repeat (3) step();
        chk("addr_held_after_redirect", bus.mem_addr_o, hold_addr);
        gnts.delete();
        pops.delete();
        gnt_pct = 100;
        wait_gnts(2, "held_grant_timeout");
        if (gnts.size() >= 2) begin
            chk("held_grant_addr", gnts[0], hold_addr);
            chk("post_redirect_addr", gnts[1], 32'h200);
        end
        wait_pops(1, "held_redirect_timeout");
        if (pops.size() >= 1) chk("held_redirect_pc", pops[0], 32'h200);
        // Redirect in a cycle that also pops and receives a response
        do_reset();
        repeat (10) step();
        pops.delete();
        do_redir = 1;
        redir_pc = 32'h300;
        step();
        @(posedge clk);
        #1;
        chk("valid_after_redirect", 32'(bus.valid_o), 32'd0);
        wait_pops(1, "coincide_timeout");
        if (pops.size() >= 1) chk("coincide_pc", pops[0], 32'h300);
        // Table of restart targets including address wrap and unaligned targets
        for (int v = 0; v < 4; v++) begin
            pops.delete();
            do_redir = 1;
            redir_pc = vt[v].target;
            step();
            wait_pops(3, "table_timeout");
            if (pops.size() >= 3) begin
                chk("table_pc0", pops[0], vt[v].e0);
                chk("table_pc1", pops[1], vt[v].e1);
                chk("table_pc2", pops[2], vt[v].e2);
            end
        end
        // Random latency, grants, stalls and redirects
        do_reset();
        lat = 0;
        gnt_pct = 70;
        rdy_pct = 70;
        redir_pct = 30;
        repeat (3000) step();
        redir_pct = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
